// File: rtl/bram_line_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bram_line_pkg : shared types and helpers for the BRAM line sequencer |
// | Revision      : 1.0                                                   |
// +----------------------------------------------------------------------+
package bram_line_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        EVICT = 2'd2
    } state_t;

    localparam int FIFO_DEPTH = 2;

    function automatic int unsigned line_addr(input int unsigned line,
                                              input int unsigned word,
                                              input int unsigned word_ofs);
        return (line << word_ofs) | word;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bram_line_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bram_line_ctrl_if : requester, writeback and BRAM port B bundle       |
// | Revision          : 1.0                                               |
// +----------------------------------------------------------------------+
interface bram_line_ctrl_if #(
    parameter int DATA_SIZE = 32,
    parameter int ADDR_SIZE = 7,
    parameter int WORD_OFS  = 2
);
    localparam int LW = ADDR_SIZE - WORD_OFS;

    logic                   evict_valid;
    logic [LW-1:0]          evict_line;
    logic                   evict_ready;
    logic                   fill_valid;
    logic [LW-1:0]          fill_line;
    logic [WORD_OFS-1:0]    fill_word;
    logic                   fill_ready;
    logic                   fill_data_valid;
    logic [DATA_SIZE-1:0]   fill_data;
    logic                   fill_data_ready;
    logic                   wb_data_valid;
    logic [DATA_SIZE-1:0]   wb_data;
    logic                   wb_data_last;
    logic                   wb_data_ready;
    logic                   busy;
    logic                   done;
    logic                   enb;
    logic [DATA_SIZE/8-1:0] web;
    logic [ADDR_SIZE-1:0]   addrb;
    logic [DATA_SIZE-1:0]   dinb;
    logic [DATA_SIZE-1:0]   doutb;

    modport master (
        output evict_valid, evict_line, fill_valid, fill_line, fill_word,
               fill_data_valid, fill_data, wb_data_ready, doutb,
        input  evict_ready, fill_ready, fill_data_ready, wb_data_valid,
               wb_data, wb_data_last, busy, done, enb, web, addrb, dinb
    );

    modport slave (
        input  evict_valid, evict_line, fill_valid, fill_line, fill_word,
               fill_data_valid, fill_data, wb_data_ready, doutb,
        output evict_ready, fill_ready, fill_data_ready, wb_data_valid,
               wb_data, wb_data_last, busy, done, enb, web, addrb, dinb
    );
endinterface
`default_nettype wire

// File: rtl/bram_line_ctrl_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bram_line_ctrl_fifo : 2-entry writeback FIFO with occupancy count     |
// | Revision            : 1.0                                             |
// +----------------------------------------------------------------------+
module bram_line_ctrl_fifo
    import bram_line_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [1:0]       cnt
);
    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [WIDTH-1:0] mem_d [FIFO_DEPTH];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             w_push;
    logic             w_pop;

    assign w_pop  = pop & (cnt_q != 2'd0);
    assign w_push = push & ((cnt_q < 2'(FIFO_DEPTH)) | w_pop);
    assign dout   = mem_q[rd_ptr_q];
    assign cnt    = cnt_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (w_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (w_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        cnt_d = cnt_q + 2'(w_push) - 2'(w_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule
`default_nettype wire

// File: rtl/bram_line_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bram_line_ctrl : line-granular EVICT/FILL sequencer for BRAM port B   |
// | Option         : BRAM_LINE_CTRL_CRITICAL_FIRST_EN (critical-word fill)|
// | Revision       : 1.0                                                  |
// +----------------------------------------------------------------------+
module bram_line_ctrl
    import bram_line_pkg::*;
#(
    parameter int DATA_SIZE = 32,
    parameter int ADDR_SIZE = 7,
    parameter int WORD_OFS  = 2
) (
    input  logic             clk,
    input  logic             rst,
    bram_line_ctrl_if.slave  bus
);
    localparam int                c_lw         = ADDR_SIZE - WORD_OFS;
    localparam logic [WORD_OFS:0] c_line_words = (WORD_OFS+1)'(1 << WORD_OFS);
    localparam logic [WORD_OFS:0] c_last_word  = c_line_words - 1'b1;

    state_t              state_q, state_d;
    logic [c_lw-1:0]     line_q, line_d;
    logic [WORD_OFS-1:0] wcnt_q, wcnt_d;
    // Reads issued during EVICT, beats written during FILL
    logic [WORD_OFS:0]   rcnt_q, rcnt_d;
    logic [WORD_OFS-1:0] bcnt_q, bcnt_d;
    logic                inflight_q, inflight_d;
    logic                done_q, done_d;

    logic [1:0]           w_fifo_cnt;
    logic [DATA_SIZE-1:0] w_fifo_dout;
    logic                 w_pop;
    logic                 w_issue;
    logic [2:0]           w_occ;
    logic [2:0]           w_lim;
    logic [WORD_OFS-1:0]  w_start_word;
    logic [ADDR_SIZE-1:0] w_addr_wr;
    logic [ADDR_SIZE-1:0] w_addr_rd;

`ifdef BRAM_LINE_CTRL_CRITICAL_FIRST_EN
    assign w_start_word = bus.fill_word;
`else
    logic w_unused_fill_word;
    assign w_unused_fill_word = ^bus.fill_word;
    assign w_start_word       = '0;
`endif

    assign w_addr_wr = ADDR_SIZE'(line_addr(32'(line_q), 32'(wcnt_q), WORD_OFS));
    assign w_addr_rd = ADDR_SIZE'(line_addr(32'(line_q), 32'(rcnt_q[WORD_OFS-1:0]), WORD_OFS));

    assign bus.busy          = (state_q != IDLE);
    assign bus.done          = done_q;
    assign bus.wb_data_valid = (w_fifo_cnt != 2'd0);
    assign bus.wb_data       = w_fifo_dout;
    assign bus.wb_data_last  = bus.wb_data_valid & (bcnt_q == '1);
    assign w_pop             = bus.wb_data_valid & bus.wb_data_ready;

    // Reads stay within what the FIFO can absorb, counting the one in flight
    assign w_occ   = 3'(w_fifo_cnt) + 3'(inflight_q);
    assign w_lim   = 3'(FIFO_DEPTH) + 3'(w_pop);
    assign w_issue = (state_q == EVICT) & (rcnt_q < c_line_words) & (w_occ < w_lim);

    always_comb begin
        state_d             = state_q;
        line_d              = line_q;
        wcnt_d              = wcnt_q;
        rcnt_d              = rcnt_q;
        bcnt_d              = bcnt_q;
        done_d              = 1'b0;
        inflight_d          = w_issue;
        bus.evict_ready     = 1'b0;
        bus.fill_ready      = 1'b0;
        bus.fill_data_ready = 1'b0;
        bus.enb             = 1'b0;
        bus.web             = '0;
        bus.addrb           = '0;
        bus.dinb            = '0;
        case (state_q)
            IDLE: begin
                bus.evict_ready = bus.evict_valid;
                bus.fill_ready  = bus.fill_valid & ~bus.evict_valid;
                rcnt_d          = '0;
                bcnt_d          = '0;
                if (bus.evict_valid) begin
                    state_d = EVICT;
                    line_d  = bus.evict_line;
                end else if (bus.fill_valid) begin
                    state_d = FILL;
                    line_d  = bus.fill_line;
                    wcnt_d  = w_start_word;
                end
            end
            FILL: begin
                bus.fill_data_ready = 1'b1;
                if (bus.fill_data_valid) begin
                    bus.enb   = 1'b1;
                    bus.web   = '1;
                    bus.addrb = w_addr_wr;
                    bus.dinb  = bus.fill_data;
                    wcnt_d    = wcnt_q + 1'b1;
                    rcnt_d    = rcnt_q + 1'b1;
                    if (rcnt_q == c_last_word) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            EVICT: begin
                if (w_issue) begin
                    bus.enb   = 1'b1;
                    bus.addrb = w_addr_rd;
                    rcnt_d    = rcnt_q + 1'b1;
                end
                if (w_pop) begin
                    bcnt_d = bcnt_q + 1'b1;
                    if (bus.wb_data_last) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            line_q     <= '0;
            wcnt_q     <= '0;
            rcnt_q     <= '0;
            bcnt_q     <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            line_q     <= line_d;
            wcnt_q     <= wcnt_d;
            rcnt_q     <= rcnt_d;
            bcnt_q     <= bcnt_d;
            inflight_q <= inflight_d;
            done_q     <= done_d;
        end
    end

    // BRAM returns 0 when disabled, so only capture the cycle after a real read
    bram_line_ctrl_fifo #(
        .WIDTH (DATA_SIZE)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (inflight_q),
        .din  (bus.doutb),
        .pop  (w_pop),
        .dout (w_fifo_dout),
        .cnt  (w_fifo_cnt)
    );
endmodule
`default_nettype wire

// File: tb/tb_bram_line_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_bram_line_ctrl : scoreboard bench for the BRAM line sequencer      |
// | Revision          : 1.0                                               |
// +----------------------------------------------------------------------+
module tb_bram_line_ctrl;
    localparam int DW = 32;
    localparam int AW = 7;
    localparam int WO = 2;
    localparam int LW = AW - WO;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bram_line_ctrl_if #(.DATA_SIZE(DW), .ADDR_SIZE(AW), .WORD_OFS(WO)) bus ();

    bram_line_ctrl #(.DATA_SIZE(DW), .ADDR_SIZE(AW), .WORD_OFS(WO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Port B memory with 1-cycle registered read, 0 when disabled
    logic [DW-1:0] bram   [0:(1<<AW)-1];
    logic [DW-1:0] shadow [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (bus.enb) begin
            if (bus.web != '0) bram[bus.addrb] <= bus.dinb;
            bus.doutb <= bram[bus.addrb];
        end else begin
            bus.doutb <= '0;
        end
    end

    logic [AW+DW-1:0] exp_wr [$];
    logic [DW:0]      exp_wb [$];
    logic [AW+DW-1:0] ew;
    logic [DW:0]      eb;
    int               n_checks = 0;
    int               n_fail   = 0;
    int               outst    = 0;
    logic             filling  = 1'b0;
    logic             prev_stall = 1'b0;
    logic [DW-1:0]    prev_data;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        #2;
        if (rst) begin
            outst      = 0;
            prev_stall = 1'b0;
        end else begin
            if (bus.enb && bus.web != '0) begin
                if (exp_wr.size() == 0) chk("unexpected_write", 1, 0);
                else begin
                    ew = exp_wr.pop_front();
                    chk("wr_addr", bus.addrb, ew[AW+DW-1:DW]);
                    chk("wr_data", bus.dinb, ew[DW-1:0]);
                    chk("wr_web", bus.web, 4'hF);
                end
            end
            if (bus.enb && bus.web == '0) begin
                outst++;
                chk("read_during_fill", filling, 0);
            end
            if (prev_stall) chk("wb_stable_on_stall", bus.wb_data, prev_data);
            if (bus.wb_data_valid && bus.wb_data_ready) begin
                outst--;
                if (exp_wb.size() == 0) chk("unexpected_wb_beat", 1, 0);
                else begin
                    eb = exp_wb.pop_front();
                    chk("wb_data", bus.wb_data, eb[DW-1:0]);
                    chk("wb_last", bus.wb_data_last, eb[DW]);
                end
            end
            if (bus.enb && bus.web == '0) chk("reads_outstanding_le2", outst <= 2, 1);
            prev_stall = bus.wb_data_valid && !bus.wb_data_ready;
            prev_data  = bus.wb_data;
        end
    end

    task automatic fill_req(input int line, input int word);
        @(negedge clk);
        bus.fill_valid = 1'b1;
        bus.fill_line  = LW'(line);
        bus.fill_word  = WO'(word);
        #2;
        chk("fill_ready", bus.fill_ready, 1);
        chk("evict_ready_idle", bus.evict_ready, 0);
    endtask

    task automatic fill_beats(input int line, input int word, input logic [DW-1:0] base, input int nb);
        int st;
        int a;
        logic [DW-1:0] d;
`ifdef BRAM_LINE_CTRL_CRITICAL_FIRST_EN
        st = word;
`else
        st = 0 * word;
`endif
        filling = 1'b1;
        for (int k = 0; k < nb; k++) begin
            @(negedge clk);
            bus.fill_valid      = 1'b0;
            d                   = base + DW'(k);
            a                   = line * (1 << WO) + ((st + k) % (1 << WO));
            bus.fill_data_valid = 1'b1;
            bus.fill_data       = d;
            exp_wr.push_back({AW'(a), d});
            shadow[a] = d;
            #2;
            chk("fill_data_ready", bus.fill_data_ready, 1);
            chk("done_during_fill", bus.done, 0);
        end
        if (nb == (1 << WO)) begin
            @(negedge clk);
            bus.fill_data_valid = 1'b0;
            #2;
            chk("fill_done", bus.done, 1);
            chk("fill_busy_clear", bus.busy, 0);
            chk("fill_writes_all_seen", exp_wr.size(), 0);
            @(negedge clk);
            #2;
            chk("fill_done_one_pulse", bus.done, 0);
        end
        filling = 1'b0;
    endtask

    task automatic do_fill(input int line, input int word, input logic [DW-1:0] base);
        fill_req(line, word);
        fill_beats(line, word, base, 1 << WO);
    endtask

    // mode 0: sink always ready with exact timing checks; mode 1: ready 1,0,0,1,...
    task automatic do_evict(input int line, input int mode, input logic hold_fill);
        int   c;
        logic seen;
        @(negedge clk);
        bus.evict_valid = 1'b1;
        bus.evict_line  = LW'(line);
        bus.fill_valid  = hold_fill;
        for (int k = 0; k < (1 << WO); k++)
            exp_wb.push_back({k == (1 << WO) - 1, shadow[line * (1 << WO) + k]});
        #2;
        chk("evict_ready", bus.evict_ready, 1);
        chk("fill_ready_lost_arb", bus.fill_ready, 0);
        seen = 1'b0;
        c    = 0;
        while (!seen && c < 60) begin
            c++;
            @(negedge clk);
            bus.evict_valid   = 1'b0;
            bus.wb_data_ready = (mode == 0) ? 1'b1 : ((c % 3) == 1);
            #2;
            if (mode == 0 && c <= 7) chk("wb_valid_timing", bus.wb_data_valid, (c >= 3 && c <= 6));
            if (bus.done) seen = 1'b1;
            else if (hold_fill) chk("fill_ready_during_evict", bus.fill_ready, 0);
        end
        chk("evict_done_seen", seen, 1);
        if (mode == 0) chk("evict_done_cycle", c, 7);
        chk("evict_busy_clear", bus.busy, 0);
        chk("wb_beats_all_seen", exp_wb.size(), 0);
        if (hold_fill) chk("fill_ready_after_evict", bus.fill_ready, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst                 = 1'b1;
        bus.evict_valid     = 1'b0;
        bus.evict_line      = '0;
        bus.fill_valid      = 1'b0;
        bus.fill_line       = '0;
        bus.fill_word       = '0;
        bus.fill_data_valid = 1'b0;
        bus.fill_data       = '0;
        bus.wb_data_ready   = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_wb_valid", bus.wb_data_valid, 0);
        chk("rst_enb", bus.enb, 0);
        chk("rst_web", bus.web, 0);
        chk("rst_evict_ready", bus.evict_ready, 0);
        chk("rst_fill_ready", bus.fill_ready, 0);
        @(negedge clk);
        rst = 1'b0;

        // Fill then write back line 5
        do_fill(5, 0, 32'h0000_00A0);
        do_evict(5, 0, 1'b0);

        // Simultaneous requests: evict wins, fill taken on the done cycle
        bus.fill_line = LW'(2);
        bus.fill_word = '0;
        do_evict(5, 0, 1'b1);
        fill_beats(2, 0, 32'h0000_0050, 1 << WO);

        // Stalling sink
        do_evict(2, 1, 1'b0);

        // Reset after two beats of a fill
        fill_req(3, 0);
        fill_beats(3, 0, 32'h0000_0070, 2);
        @(negedge clk);
        bus.fill_data_valid = 1'b0;
        rst = 1'b1;
        #2;
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_enb", bus.enb, 0);
        chk("abort_fill_data_ready", bus.fill_data_ready, 0);
        @(negedge clk);
        #2;
        chk("abort_no_done", bus.done, 0);
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk("abort_no_done_after", bus.done, 0);
        do_fill(3, 0, 32'h0000_0090);
        do_evict(3, 0, 1'b0);

        // Critical-word fill on line 1
        do_fill(1, 3, 32'h0000_00C0);
        do_evict(1, 0, 1'b0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
